// File: rtl/pin_conditioner_pkg.sv
// Shared types for the input pin conditioner.
// Holds the per-channel debounce state encoding.
package pin_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } deb_state_e;

endpackage

// File: rtl/pin_debounce_channel.sv
// One input pin: optional inversion, 2-flop synchronizer, debounce FSM, and registered edge pulses.
//
// state     | meaning
// IDLE_LOW  | accepted level 0, synced input agrees
// CHK_HIGH  | synced input went 1, counting qualified ticks toward acceptance
// IDLE_HIGH | accepted level 1, synced input agrees
// CHK_LOW   | synced input went 0, counting qualified ticks toward acceptance
import pin_conditioner_pkg::*;

module pin_debounce_channel #(
  parameter int NrOfBits    = 20,
  parameter int StableCount = 500000,
  parameter bit ActiveLow   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_raw,
  input  logic sample_tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [NrOfBits-1:0] LastCnt = NrOfBits'(StableCount - 1);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  deb_state_e          state_q, state_d;
  logic [NrOfBits-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The completing edge still samples the synced input, so a last-cycle drop aborts.
  always_comb begin
    sync1_d = pin_raw ^ ActiveLow;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync2_q) begin
          state_d = CHK_HIGH;
          cnt_d   = '0;
        end
      end
      CHK_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (sample_tick) begin
          if (cnt_q == LastCnt) begin
            state_d = IDLE_HIGH;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      IDLE_HIGH: begin
        if (!sync2_q) begin
          state_d = CHK_LOW;
          cnt_d   = '0;
        end
      end
      CHK_LOW: begin
        if (sync2_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (sample_tick) begin
          if (cnt_q == LastCnt) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pin_conditioner.sv
// Synchronizes and debounces raw board pins into clean levels and one-cycle edge pulses.
import pin_conditioner_pkg::*;

module pin_conditioner #(
  parameter int NrOfPins    = 2,
  parameter int NrOfBits    = 20,
  parameter int StableCount = 500000,
  parameter bit ActiveLow   = 1'b0
) (
  input  logic                FPGAClock,
  input  logic                RST,
  input  logic [NrOfPins-1:0] PinRaw,
  input  logic                SampleTick,
  output logic [NrOfPins-1:0] PinLevel,
  output logic [NrOfPins-1:0] PinRise,
  output logic [NrOfPins-1:0] PinFall
);

  for (genvar g = 0; g < NrOfPins; g++) begin : g_ch
    pin_debounce_channel #(
      .NrOfBits    (NrOfBits),
      .StableCount (StableCount),
      .ActiveLow   (ActiveLow)
    ) u_ch (
      .clk         (FPGAClock),
      .rst         (RST),
      .pin_raw     (PinRaw[g]),
      .sample_tick (SampleTick),
      .level       (PinLevel[g]),
      .rise        (PinRise[g]),
      .fall        (PinFall[g])
    );
  end

endmodule

// File: tb/tb_pin_conditioner.sv
// Self-checking bench for pin_conditioner: vector table, directed corner sequences, random run vs reference model.
module tb_pin_conditioner;

  localparam int NP = 2;
  localparam int NB = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [NP-1:0] raw, raw_al;
  logic [NP-1:0] lvl, rse, fll;
  logic [NP-1:0] lvl_al, rse_al, fll_al;

  always #5 clk = ~clk;

  pin_conditioner #(.NrOfPins(NP), .NrOfBits(NB), .StableCount(SC), .ActiveLow(1'b0)) u_dut (
    .FPGAClock(clk), .RST(rst), .PinRaw(raw), .SampleTick(tick),
    .PinLevel(lvl), .PinRise(rse), .PinFall(fll)
  );

  pin_conditioner #(.NrOfPins(NP), .NrOfBits(NB), .StableCount(SC), .ActiveLow(1'b1)) u_dut_al (
    .FPGAClock(clk), .RST(rst), .PinRaw(raw_al), .SampleTick(tick),
    .PinLevel(lvl_al), .PinRise(rse_al), .PinFall(fll_al)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference model: a pin is accepted once its synced value has differed from the
  // accepted level continuously for SC qualified ticks after the mismatch is first seen.
  typedef struct {
    logic s1, s2, level, checking, rise, fall;
    int   prog;
  } mch_t;

  mch_t m[2][NP];
  logic model_en = 1'b0;

  function automatic mch_t mstep(input mch_t c, input logic in_v, input logic t);
    mch_t n;
    logic s;
    n = c;
    s = c.s2;
    n.s2 = c.s1;
    n.s1 = in_v;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (!c.checking) begin
      if (s != c.level) begin
        n.checking = 1'b1;
        n.prog = 0;
      end
    end else if (s == c.level) begin
      n.checking = 1'b0;
    end else if (t) begin
      n.prog = c.prog + 1;
      if (n.prog == SC) begin
        n.level = s;
        n.checking = 1'b0;
        n.rise = s;
        n.fall = !s;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NP; c++) begin
        if (rst) m[d][c] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        else m[d][c] = mstep(m[d][c], (d == 1) ? ~raw_al[c] : raw[c], tick);
      end
  end

  logic [1:0] el [2], er [2], ef [2];

  always @(negedge clk) begin
    if (model_en) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NP; c++) begin
          el[d][c] = m[d][c].level;
          er[d][c] = m[d][c].rise;
          ef[d][c] = m[d][c].fall;
        end
      chk("model_level", lvl, el[0]);
      chk("model_rise", rse, er[0]);
      chk("model_fall", fll, ef[0]);
      chk("model_level_al", lvl_al, el[1]);
      chk("model_rise_al", rse_al, er[1]);
      chk("model_fall_al", fll_al, ef[1]);
    end
  end

  typedef struct {
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Entry i: raw applied before edge i after reset release, outputs expected after edge i.
    vecs[0]  = '{2'b01, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{2'b01, 2'b00, 2'b00, 2'b00};
    vecs[2]  = '{2'b01, 2'b00, 2'b00, 2'b00};
    vecs[3]  = '{2'b01, 2'b00, 2'b00, 2'b00};
    vecs[4]  = '{2'b01, 2'b00, 2'b00, 2'b00};
    vecs[5]  = '{2'b01, 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{2'b01, 2'b01, 2'b01, 2'b00};
    vecs[7]  = '{2'b01, 2'b01, 2'b00, 2'b00};
    vecs[8]  = '{2'b10, 2'b01, 2'b00, 2'b00};
    vecs[9]  = '{2'b10, 2'b01, 2'b00, 2'b00};
    vecs[10] = '{2'b10, 2'b01, 2'b00, 2'b00};
    vecs[11] = '{2'b10, 2'b01, 2'b00, 2'b00};
    vecs[12] = '{2'b10, 2'b01, 2'b00, 2'b00};
    vecs[13] = '{2'b10, 2'b01, 2'b00, 2'b00};
    vecs[14] = '{2'b10, 2'b10, 2'b10, 2'b01};
    vecs[15] = '{2'b10, 2'b10, 2'b00, 2'b00};

    rst = 1'b1;
    raw = 2'b01;
    raw_al = 2'b11;
    tick = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_en = 1'b1;
    chk("reset_level", lvl, 2'b00);
    chk("reset_rise", rse, 2'b00);
    chk("reset_fall", fll, 2'b00);
    chk("reset_level_al", lvl_al, 2'b00);
    rst = 1'b0;

    // Startup press on ch0, then simultaneous ch0 release / ch1 press.
    for (int i = 0; i < 16; i++) begin
      raw = vecs[i].raw;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_level", i), lvl, vecs[i].lvl);
      chk($sformatf("vec%0d_rise", i), rse, vecs[i].rise);
      chk($sformatf("vec%0d_fall", i), fll, vecs[i].fall);
    end

    // Glitch rejection: 3-cycle pulses never accepted.
    repeat (5) begin
      for (int j = 0; j < 6; j++) begin
        raw[0] = (j < 3);
        @(posedge clk); #1;
        chk("glitch_level", {1'b0, lvl[0]}, 2'b00);
        chk("glitch_rise", {1'b0, rse[0]}, 2'b00);
      end
    end
    raw[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Drop seen on the completing edge aborts; rise follows a fresh full count.
    for (int j = 0; j < 14; j++) begin
      raw[0] = (j != 4);
      @(posedge clk); #1;
      chk($sformatf("bounce_rise_e%0d", j), {1'b0, rse[0]}, {1'b0, j == 11});
      chk($sformatf("bounce_level_e%0d", j), {1'b0, lvl[0]}, {1'b0, j >= 11});
    end
    raw[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Sparse SampleTick: only qualified edges advance the count.
    for (int j = 0; j < 19; j++) begin
      raw[0] = 1'b1;
      tick = ((j % 4) == 3);
      @(posedge clk); #1;
      chk($sformatf("tick_rise_e%0d", j), {1'b0, rse[0]}, {1'b0, j == 15});
      chk($sformatf("tick_level_e%0d", j), {1'b0, lvl[0]}, {1'b0, j >= 15});
    end
    tick = 1'b1;
    raw[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Async reset mid-check (cnt=2) discards progress; held pins re-debounce.
    for (int j = 0; j < 5; j++) begin
      raw[0] = 1'b1;
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_level", lvl, 2'b00);
    chk("midrst_rise", rse, 2'b00);
    chk("midrst_fall", fll, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      chk($sformatf("rerun_rise_e%0d", j), rse, (j == 6) ? 2'b11 : 2'b00);
      chk($sformatf("rerun_fall_e%0d", j), fll, 2'b00);
    end

    // Inverted pins: raw 0 counts as pressed.
    for (int j = 0; j < 8; j++) begin
      raw_al[0] = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("al_rise_e%0d", j), rse_al, (j == 6) ? 2'b01 : 2'b00);
      chk($sformatf("al_level_e%0d", j), lvl_al, (j >= 6) ? 2'b01 : 2'b00);
    end

    // Random run against the reference model.
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      for (int c = 0; c < NP; c++) begin
        if ($urandom_range(0, 7) == 0) raw[c] = ~raw[c];
        if ($urandom_range(0, 7) == 0) raw_al[c] = ~raw_al[c];
      end
      tick = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
